// File: rtl/rbcp_reg_responder.sv
// RBCP local-bus slave: R/W configuration byte bank, read-only status window
// and a write-only command-pulse register, acknowledged after ACK_LAT cycles.
module rbcp_reg_responder #(
    parameter logic [31:0]           BASE_ADDR = 32'h0000_0000,
    parameter int unsigned           NUM_REGS  = 16,
    parameter int unsigned           NUM_STAT  = 8,
    parameter int unsigned           ACK_LAT   = 2,
    parameter logic [NUM_REGS*8-1:0] REG_INIT  = '0
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  LOC_ACT,
    input  logic [31:0]           LOC_ADDR,
    input  logic [7:0]            LOC_WD,
    input  logic                  LOC_WE,
    input  logic                  LOC_RE,
    output logic                  LOC_ACK,
    output logic [7:0]            LOC_RD,
    output logic [NUM_REGS*8-1:0] REG_OUT,
    input  logic [NUM_STAT*8-1:0] STAT_IN,
    output logic [7:0]            CMD_PULSE,
    output logic                  BUSY
);

    // WAIT is entered in cycle 1 and ACK must land in cycle ACK_LAT.
    localparam logic [1:0] WAIT_LOAD = (ACK_LAT > 2) ? 2'(ACK_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              cnt;
    logic [NUM_REGS*8-1:0]   reg_q;
    logic [7:0]              rd_q;
    logic [7:0]              cmd_q;
    logic [7:0]              rd_data;
    logic [31:0]             offset;
    logic                    hit_reg;
    logic                    hit_cmd;
    logic                    hit_stat;
    logic                    req;

    // Modulo subtraction makes addresses below BASE_ADDR wrap to huge offsets.
    assign offset   = LOC_ADDR - BASE_ADDR;
    assign hit_reg  = (offset < NUM_REGS);
    assign hit_cmd  = (offset == 32'h0000_007F);
    assign hit_stat = (offset >= 32'h0000_0080) && (offset < 32'h0000_0080 + NUM_STAT);
    assign req      = (state == S_IDLE) && LOC_ACT && (LOC_WE || LOC_RE)
                      && (hit_reg || hit_cmd || hit_stat);

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (offset == i) rd_data = reg_q[i*8 +: 8];
        end
        for (int unsigned j = 0; j < NUM_STAT; j++) begin
            if (offset == 32'h0000_0080 + j) rd_data = STAT_IN[j*8 +: 8];
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req) state_nxt = (ACK_LAT <= 1) ? S_ACK : S_WAIT;
            S_WAIT: begin
                if (!LOC_ACT)      state_nxt = S_IDLE;
                else if (cnt == 0) state_nxt = S_ACK;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            reg_q <= REG_INIT;
            rd_q  <= '0;
            cmd_q <= '0;
            cnt   <= '0;
        end else begin
            cmd_q <= '0;
            if (req) begin
                cnt <= WAIT_LOAD;
                // Write wins over a simultaneous read and returns zero data.
                if (LOC_WE) begin
                    rd_q <= '0;
                    if (hit_cmd) cmd_q <= LOC_WD;
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (offset == i) reg_q[i*8 +: 8] <= LOC_WD;
                    end
                end else begin
                    rd_q <= rd_data;
                end
            end else if ((state == S_WAIT) && (cnt != 0)) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    assign LOC_ACK   = (state == S_ACK);
    assign LOC_RD    = LOC_ACK ? rd_q : '0;
    assign BUSY      = (state != S_IDLE);
    assign REG_OUT   = reg_q;
    assign CMD_PULSE = cmd_q;

endmodule

// File: doc/rbcp_reg_responder.md
Name: rbcp_reg_responder

Overview:
- Slave end of the RBCP local bus; SiTCP is the initiator.
- Decodes the 32-bit LOC_ADDR and serves a bank of read/write configuration registers, a read-only status window and a write-only command-pulse register.
- Returns LOC_ACK/LOC_RD to SiTCP after a programmable latency.
- Sits in the user clock domain, alongside the SiTCP core.

Parameters:
BASE_ADDR, 32'h0000_0000, address of register 0; all windows are offsets from it
NUM_REGS, 16, number of R/W byte registers at offsets 0x00..NUM_REGS-1 (1..64)
NUM_STAT, 8, number of read-only status bytes at offsets 0x80..0x80+NUM_STAT-1 (1..64)
ACK_LAT, 2, cycles from request sample to LOC_ACK (1..4)
REG_INIT, all 0, flat NUM_REGS*8 reset image of R/W bank

Ports:
CLK  in  1  system clock; all logic on rising edge
RSTn  in  1  asynchronous active-low reset
LOC_ACT  in  1  RBCP transaction active
LOC_ADDR  in  32  byte address
LOC_WD  in  8  write data
LOC_WE  in  1  write strobe, 1-cycle pulse
LOC_RE  in  1  read strobe, 1-cycle pulse
LOC_ACK  out  1  access acknowledge, 1-cycle pulse
LOC_RD  out  8  read data, valid only while LOC_ACK=1
REG_OUT  out  NUM_REGS*8  R/W bank, byte k at [8k+7:8k]
STAT_IN  in  NUM_STAT*8  status bytes, same packing
CMD_PULSE  out  8  one-cycle pulse per bit written to offset 0x7F
BUSY  out  1  high from request sample through the ACK cycle

Behaviour:
- Reset (RSTn=0, async):
  - REG_OUT=REG_INIT; LOC_ACK=0, LOC_RD=0, CMD_PULSE=0, BUSY=0.
  - FSM goes to IDLE.
  - Release is synchronous to CLK.
- Offset = LOC_ADDR-BASE_ADDR, computed 32-bit modulo; wrap below BASE is out of range. Decode:
  - 0x00..NUM_REGS-1: R/W bank.
  - 0x7F: command register; write generates pulses, read returns 0x00.
  - 0x80..0x80+NUM_STAT-1: status, read-only.
  - Anything else is unmapped.
- FSM IDLE -> WAIT -> ACK -> IDLE:
  - IDLE: a request is sampled when LOC_ACT=1 and (LOC_WE|LOC_RE)=1. Capture the decode and go to WAIT, or directly to ACK if ACK_LAT=1.
  - Write to R/W byte: commits at the sample edge; REG_OUT changes in cycle 1.
  - Write to 0x7F: CMD_PULSE=LOC_WD for exactly cycle 1, then 0.
  - Write to status window: ignored, but still acknowledged.
  - Read: the data byte is latched at the sample edge (STAT_IN sampled then).
  - WAIT: count down; enter ACK so that LOC_ACK is high in cycle ACK_LAT (sample = cycle 0).
  - ACK: LOC_ACK=1 for one cycle; LOC_RD=latched byte (0 for writes). Next cycle returns to IDLE with LOC_RD=0.
- Unmapped address: no state change and no ACK. The FSM stays IDLE and SiTCP times out, reporting a bus error. BUSY stays 0.
- LOC_WE and LOC_RE together: the write takes priority; a single ACK is issued with LOC_RD=0.
- Strobes while BUSY=1 are ignored; no queueing.
- LOC_ACT drops in WAIT: abort to IDLE, no ACK. A write already committed stays committed.
- LOC_ACT drops in the ACK cycle: ACK still completes.
- Strobes with LOC_ACT=0: ignored.
- Read of the same register written in the previous transaction returns the new value.

Test Plan:
- Reset: RSTn low mid-WAIT -> LOC_ACK=0 immediately, REG_OUT=REG_INIT. After release, a read of offset 0x03 acks with REG_INIT byte 3.
- Write/readback, ACK_LAT=2:
  - WE, addr BASE+0x05, WD=0xA5 -> REG_OUT[47:40]=0xA5 at cycle 1; LOC_ACK=1 at cycle 2 only, LOC_RD=0.
  - Then RE same addr -> LOC_ACK at cycle 2 with LOC_RD=0xA5; LOC_RD=0 at cycle 3.
- Status and command:
  - STAT_IN byte 2=0x3C; RE at BASE+0x82 -> LOC_RD=0x3C.
  - WE at 0x7F, WD=0x81 -> CMD_PULSE=0x81 for one cycle, then 0x00.
  - RE at 0x7F -> LOC_RD=0x00.
- Unmapped/wrap:
  - RE at BASE+0x40 (NUM_REGS=16) -> no ACK over 20 cycles, BUSY=0.
  - RE at BASE-1 -> no ACK.
- Protocol edges:
  - WE+RE together to 0x01, WD=0x11 -> REG byte 1=0x11, one ACK, LOC_RD=0.
  - Second WE during BUSY is ignored.
  - LOC_ACT drops in WAIT with ACK_LAT=4 -> no ACK; the written value is retained.
- Latency sweep: ACK_LAT=1 and 4 -> ACK exactly at cycle 1 and cycle 4 respectively, always one cycle wide.
